btn_conditioner: RTL and testbench



---
 rtl/btn_conditioner_pkg.sv | 21 ++
 rtl/btn_conditioner_chan.sv | 104 ++++++++++
 rtl/btn_conditioner.sv | 36 +++
 tb/tb_btn_conditioner.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared types and board timing defaults for the push-button conditioner.
// Channel FSM states keep their legacy encodings.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  // 100 MHz board: 20 ms debounce, 500 ms first repeat, 100 ms repeat period
  localparam int unsigned DB_CYCLES_100MHZ         = 2000000;
  localparam int unsigned RPT_DELAY_CYCLES_100MHZ  = 50000000;
  localparam int unsigned RPT_PERIOD_CYCLES_100MHZ = 10000000;

  // 50 MHz board: same wall-clock timings
  localparam int unsigned DB_CYCLES_50MHZ          = 1000000;
  localparam int unsigned RPT_DELAY_CYCLES_50MHZ   = 25000000;
  localparam int unsigned RPT_PERIOD_CYCLES_50MHZ  = 5000000;

endpackage

// File: rtl/btn_conditioner_chan.sv
// One button channel: 2-flop synchronizer, counter debounce, and a
// press/release pulse FSM with optional auto-repeat while held.
module btn_chan
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES         = DB_CYCLES_100MHZ,
  parameter int unsigned RPT_DELAY_CYCLES  = RPT_DELAY_CYCLES_100MHZ,
  parameter int unsigned RPT_PERIOD_CYCLES = RPT_PERIOD_CYCLES_100MHZ,
  parameter bit          RPT_EN            = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
  localparam int unsigned RPT_MAX = (RPT_DELAY_CYCLES > RPT_PERIOD_CYCLES) ?
                                    RPT_DELAY_CYCLES : RPT_PERIOD_CYCLES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST         = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(RPT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(RPT_PERIOD_CYCLES - 1);

  logic             s1, s2;
  logic [DB_W-1:0]  db_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic             mismatch, flip, rise, fall;
  logic             press_nxt, release_nxt, rpt_clr, rpt_due;
  btn_state_e       state, state_nxt;

  always_comb begin
    mismatch = s2 ^ btn_level;
    flip     = mismatch && (db_cnt == DB_LAST);
    rise     = flip && !btn_level;
    fall     = flip && btn_level;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      // any agreeing cycle restarts the qualification window
      if (!mismatch || flip) db_cnt <= '0;
      else                   db_cnt <= db_cnt + 1'b1;
      if (flip) btn_level <= ~btn_level;
    end
  end

  always_comb begin
    state_nxt   = state;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    rpt_clr     = 1'b0;
    rpt_due     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          press_nxt = 1'b1;
          rpt_clr   = 1'b1;
          state_nxt = HELD;
        end
      end
      HELD, REPEAT: begin
        rpt_due = RPT_EN &&
                  (rpt_cnt == ((state == HELD) ? RPT_DELAY_LAST : RPT_PERIOD_LAST));
        // a release on the same edge as a repeat tick suppresses the tick
        if (fall) begin
          release_nxt = 1'b1;
          state_nxt   = IDLE;
        end else if (rpt_due) begin
          press_nxt = 1'b1;
          rpt_clr   = 1'b1;
          state_nxt = REPEAT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rpt_cnt     <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      if (rpt_clr || (state_nxt == IDLE) || !RPT_EN) rpt_cnt <= '0;
      else                                           rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw push-buttons into debounced levels and one-cycle
// press/release pulses; auto-repeat is enabled per channel by RPT_MASK.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned          N_BTN             = 3,
  parameter int unsigned          DB_CYCLES         = DB_CYCLES_100MHZ,
  parameter int unsigned          RPT_DELAY_CYCLES  = RPT_DELAY_CYCLES_100MHZ,
  parameter int unsigned          RPT_PERIOD_CYCLES = RPT_PERIOD_CYCLES_100MHZ,
  parameter logic [N_BTN-1:0]     RPT_MASK          = 3'b110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DB_CYCLES        (DB_CYCLES),
      .RPT_DELAY_CYCLES (RPT_DELAY_CYCLES),
      .RPT_PERIOD_CYCLES(RPT_PERIOD_CYCLES),
      .RPT_EN           (RPT_MASK[i])
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random button activity,
// all outputs compared every cycle against a timing-rule reference model.
module tb_btn_conditioner;

  localparam int         DB   = 4;
  localparam int         RD   = 20;
  localparam int         RP   = 8;
  localparam logic [2:0] MASK = 3'b110;

  logic       clk;
  logic       rst;
  logic [2:0] btn_raw;
  logic [2:0] btn_level, btn_press, btn_release;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: raw samples seen 1 and 2 edges ago, stable level,
  // mismatch run length, cycles since last press pulse, pulses in this hold
  logic [2:0] raw_d1, raw_d2, m_lvl, m_press, m_rel;
  int         m_run[3], m_hold[3], m_ticks[3];

  btn_conditioner #(
    .N_BTN            (3),
    .DB_CYCLES        (DB),
    .RPT_DELAY_CYCLES (RD),
    .RPT_PERIOD_CYCLES(RP),
    .RPT_MASK         (MASK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [2:0] raw, input logic r);
    if (r) begin
      raw_d1 = '0; raw_d2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
      for (int ch = 0; ch < 3; ch++) begin
        m_run[ch] = 0; m_hold[ch] = 0; m_ticks[ch] = 0;
      end
    end else begin
      m_press = '0;
      m_rel   = '0;
      for (int ch = 0; ch < 3; ch++) begin
        bit rose;
        rose = 1'b0;
        if (raw_d2[ch] != m_lvl[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DB) begin
            m_run[ch] = 0;
            m_lvl[ch] = ~m_lvl[ch];
            if (m_lvl[ch]) begin
              m_press[ch] = 1'b1; m_hold[ch] = 0; m_ticks[ch] = 1; rose = 1'b1;
            end else begin
              m_rel[ch] = 1'b1;
            end
          end
        end else begin
          m_run[ch] = 0;
        end
        if (m_lvl[ch] && !rose) begin
          m_hold[ch]++;
          if (MASK[ch] && m_hold[ch] == ((m_ticks[ch] == 1) ? RD : RP)) begin
            m_press[ch] = 1'b1; m_hold[ch] = 0; m_ticks[ch]++;
          end
        end
      end
      raw_d2 = raw_d1;
      raw_d1 = raw;
    end
  endtask

  task automatic cyc(input logic [2:0] raw, input logic r);
    @(negedge clk);
    btn_raw = raw;
    rst     = r;
    @(posedge clk);
    model_edge(raw, r);
    #1;
    check("level",   btn_level,   m_lvl);
    check("press",   btn_press,   m_press);
    check("release", btn_release, m_rel);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(3'b000, 1'b0);
  endtask

  int   cnt;
  int   rel_at;
  int   rep_at[$];
  int   exp_rep[6] = '{6, 26, 34, 42, 50, 58};

  initial begin
    btn_raw = 3'b111;
    rst     = 1'b1;

    // reset with buttons held: everything stays low, then all qualify together
    for (int k = 0; k < 3; k++) begin
      cyc(3'b111, 1'b1);
      check("rst_outputs", {btn_level, btn_press, btn_release}, 9'd0);
    end
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(3'b111, 1'b0);
      if (k == 5) check("rst_level_pre", btn_level, 3'b000);
      if (k == 6) check("rst_press", btn_press, 3'b111);
      if (k == 6) check("rst_level", btn_level, 3'b111);
      if (btn_press[0]) cnt++;
    end
    check("rst_ch0_no_repeat", cnt, 1);
    idle(12);

    // clean press/release on ch0
    cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      cyc((k <= 40) ? 3'b001 : 3'b000, 1'b0);
      if (k == 6)  check("clean_press", btn_press, 3'b001);
      if (k == 45) check("clean_level_held", btn_level, 3'b001);
      if (k == 46) check("clean_release", btn_release, 3'b001);
      if (btn_press[0]) cnt++;
    end
    check("clean_press_count", cnt, 1);

    // bouncing ch0 settles high from sample 11
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc((k <= 10) ? {2'b00, 1'(((k - 1) / 2) % 2)} : 3'b001, 1'b0);
      if (k == 16) check("bounce_press", btn_press, 3'b001);
      if (btn_press[0]) cnt++;
    end
    check("bounce_press_count", cnt, 1);
    idle(12);

    // auto-repeat on ch1
    rep_at.delete();
    rel_at = -1;
    for (int k = 1; k <= 70; k++) begin
      cyc((k <= 56) ? 3'b010 : 3'b000, 1'b0);
      if (btn_press[1]) rep_at.push_back(k);
      if (btn_release[1]) rel_at = k;
    end
    check("rep_count", rep_at.size(), 6);
    for (int i = 0; i < 6 && i < rep_at.size(); i++) check("rep_edge", rep_at[i], exp_rep[i]);
    check("rep_release_edge", rel_at, 62);
    idle(4);

    // repeat tick colliding with release on ch2
    for (int k = 1; k <= 45; k++) begin
      cyc((k <= 28) ? 3'b100 : 3'b000, 1'b0);
      if (k == 26) check("coll_first_repeat", btn_press, 3'b100);
      if (k == 34) check("coll_no_press", btn_press, 3'b000);
      if (k == 34) check("coll_release", btn_release, 3'b100);
    end
    idle(4);

    // synchronous reset while ch1 is in repeat
    for (int k = 1; k <= 45; k++) begin
      cyc((k <= 40) ? 3'b010 : 3'b000, k == 31);
      if (k == 31) check("midrst_outputs", {btn_level, btn_press, btn_release}, 9'd0);
      if (k == 36) check("midrst_level_pre", btn_level, 3'b000);
      if (k == 37) check("midrst_press", btn_press, 3'b010);
    end
    idle(12);

    // random activity: short bursts act as bounce, long holds reach repeat
    for (int seg = 0; seg < 160; seg++) begin
      logic [2:0] rv;
      int         len;
      logic       do_rst;
      rv     = 3'($urandom);
      len    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                           : int'($urandom_range(1, 7));
      do_rst = ($urandom_range(0, 40) == 0);
      for (int k = 0; k < len; k++) cyc(rv, do_rst && (k == 0));
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
